rgb_stream_reader: RTL

//  Pixel-fetch front end of the VGA output path. Reads 12-bit {R,G,B} pixels from an upstream

---
 rtl/rgb_stream_reader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rgb_stream_reader.sv
// Pixel-fetch front end of the VGA output path: prefetches {R,G,B} pixels from a
// valid/ready stream and emits one registered pixel per display-enable cycle, with per-line underflow recovery.
module rgb_stream_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int H_ACTIVE   = 640
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               frame_start,
  input  logic                               de,
  input  logic                               s_valid,
  input  logic [11:0]                        s_data,
  input  logic                               s_last,
  output logic                               s_ready,
  output logic [3:0]                         q_r,
  output logic [3:0]                         q_g,
  output logic [3:0]                         q_b,
  output logic                               de_out,
  output logic                               underflow,
  input  logic                               clr_err,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(H_ACTIVE + 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(H_ACTIVE);

  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, DRAIN} state_t;

  state_t        state, state_nxt;
  logic          de_q;
  logic [12:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [CW-1:0] pop_cnt;
  logic [12:0]   rd_entry;
  logic          unused_last;

  logic full, empty, de_rise, want_pop, pop, push, uf_set;

  assign fifo_level  = level;
  assign rd_entry    = mem[rd_ptr];
  // The stored last flag only matters on the write side (DRAIN exit); it is never replayed.
  assign unused_last = rd_entry[12];

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    full      = (level == FULL_LEVEL);
    empty     = (level == '0);
    de_rise   = de & ~de_q;
    want_pop  = 1'b0;
    s_ready   = 1'b0;
    state_nxt = state;

    // The rising-edge cycle in SYNC is already the first visible pixel of the line.
    if (!frame_start && de) begin
      if (state == SYNC && de_rise)                     want_pop = 1'b1;
      else if (state == ACTIVE && pop_cnt < LAST_COUNT) want_pop = 1'b1;
    end
    pop    = want_pop & ~empty;
    uf_set = want_pop & empty;

    case (state)
      IDLE:    s_ready = 1'b0;
      DRAIN:   s_ready = 1'b1;
      default: s_ready = ~full;
    endcase
    push = s_valid & s_ready & (state == SYNC || state == ACTIVE) & ~frame_start;

    if (frame_start) begin
      state_nxt = SYNC;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        SYNC:    if (uf_set) state_nxt = DRAIN; else if (de_rise) state_nxt = ACTIVE;
        ACTIVE:  if (uf_set) state_nxt = DRAIN; else if (!de) state_nxt = SYNC;
        DRAIN:   if (s_valid && s_last) state_nxt = SYNC;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_last, s_data};
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      de_q      <= 1'b0;
      de_out    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pop_cnt   <= '0;
      q_r       <= '0;
      q_g       <= '0;
      q_b       <= '0;
      underflow <= 1'b0;
    end else begin
      state  <= state_nxt;
      de_q   <= de;
      de_out <= de;

      if (pop) {q_r, q_g, q_b} <= rd_entry[11:0];
      else     {q_r, q_g, q_b} <= 12'h000;

      if (uf_set)       underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;

      if (frame_start) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level   <= '0;
        pop_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
        if (pop)                pop_cnt <= (state == SYNC) ? CW'(1) : pop_cnt + 1'b1;
        else if (state == SYNC) pop_cnt <= '0;
      end
    end
  end

endmodule
